// File: rtl/pll_cen_gen_if.sv
// Configuration and enable bus of the fractional clock-enable generator.
// The master side programs channels; the slave side (the generator) reports
// handshake status, rejection pulses, enable strobes and lock.
interface pll_cen_gen_if #(
    parameter int NUM_CH = 3,
    parameter int ACC_W  = 16
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [2:0]        cfg_ch;
    logic [ACC_W-1:0]  cfg_num;
    logic [ACC_W-1:0]  cfg_den;
    logic [ACC_W-1:0]  cfg_phase;
    logic              cfg_err;
    logic [NUM_CH-1:0] cen;
    logic              locked;

    modport master (
        output cfg_valid, cfg_ch, cfg_num, cfg_den, cfg_phase,
        input  cfg_ready, cfg_err, cen, locked
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_num, cfg_den, cfg_phase,
        output cfg_ready, cfg_err, cen, locked
    );
endinterface

// File: rtl/pll_cen_gen.sv
// Multi-channel fractional clock-enable generator with settle/lock tracking.
// Each channel is a phase accumulator producing cen[i] at an average rate of
// num/den of refclk. Any accepted reconfiguration re-enters a settle window
// during which all enables are held low and all accumulators freeze, so the
// channels restart phase-aligned when lock returns.
module pll_cen_gen #(
    parameter int NUM_CH      = 3,
    parameter int ACC_W       = 16,
    parameter int LOCK_CYCLES = 16
) (
    input  logic          refclk,
    input  logic          rst,
    pll_cen_gen_if.slave  cfg
);
    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [3:0]       CH_LIM   = 4'(NUM_CH);

    typedef enum logic [0:0] {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic               ready_r;
    logic               err_r;
    logic               locked_r;
    logic [NUM_CH-1:0]  cen_r;

    logic [ACC_W-1:0]   num_r [NUM_CH];
    logic [ACC_W-1:0]   den_r [NUM_CH];
    logic [ACC_W-1:0]   acc_r [NUM_CH];

    logic [ACC_W:0]     sum_s     [NUM_CH];
    logic [ACC_W-1:0]   acc_nxt_s [NUM_CH];
    logic [NUM_CH-1:0]  hit_s;

    logic               accept_s;
    logic               cfg_ok_s;
    logic               load_s;
    logic               running_s;
    logic [ACC_W-1:0]   phase_ld_s;

    // Write acceptance and validation of the presented configuration.
    always_comb begin
        accept_s   = cfg.cfg_valid & ready_r;
        cfg_ok_s   = (cfg.cfg_den != {ACC_W{1'b0}}) &&
                     (cfg.cfg_num != {ACC_W{1'b0}}) &&
                     (cfg.cfg_num <= cfg.cfg_den) &&
                     ({1'b0, cfg.cfg_ch} < CH_LIM);
        load_s     = accept_s & cfg_ok_s;
        running_s  = (state_r == ST_LOCKED) & ~load_s;
        if (cfg.cfg_phase >= cfg.cfg_den) begin
            phase_ld_s = cfg.cfg_den - ACC_W'(1);
        end else begin
            phase_ld_s = cfg.cfg_phase;
        end
    end

    // Per-channel accumulator step: wide sum for the compare, modular next value.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sum_s[i] = {1'b0, acc_r[i]} + {1'b0, num_r[i]};
            hit_s[i] = (sum_s[i] >= {1'b0, den_r[i]});
            if (hit_s[i]) begin
                acc_nxt_s[i] = acc_r[i] + num_r[i] - den_r[i];
            end else begin
                acc_nxt_s[i] = acc_r[i] + num_r[i];
            end
        end
    end

    // Settle/lock next-state logic and settle counter.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_SETTLE: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_LOCKED;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_SETTLE;
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_LOCKED: begin
                cnt_s = {CNT_W{1'b0}};
                if (load_s) begin
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_LOCKED;
                end
            end
            default: begin
                state_s = ST_SETTLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State register plus registered handshake, error and lock outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_SETTLE;
            cnt_r    <= {CNT_W{1'b0}};
            ready_r  <= 1'b0;
            err_r    <= 1'b0;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            ready_r  <= (state_s == ST_LOCKED);
            locked_r <= (state_s == ST_LOCKED);
            err_r    <= accept_s & ~cfg_ok_s;
        end
    end

    // Channel ratio registers, accumulators and registered enable strobes.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                num_r[i] <= ACC_W'(1);
                den_r[i] <= ACC_W'(1);
                acc_r[i] <= {ACC_W{1'b0}};
            end
            cen_r <= {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (load_s && (cfg.cfg_ch == 3'(i))) begin
                    num_r[i] <= cfg.cfg_num;
                    den_r[i] <= cfg.cfg_den;
                    acc_r[i] <= phase_ld_s;
                end else if (running_s) begin
                    acc_r[i] <= acc_nxt_s[i];
                end else begin
                    acc_r[i] <= acc_r[i];
                end
                cen_r[i] <= running_s & hit_s[i];
            end
        end
    end

    assign cfg.cfg_ready = ready_r;
    assign cfg.cfg_err   = err_r;
    assign cfg.locked    = locked_r;
    assign cfg.cen       = cen_r;
endmodule

// File: tb/tb_pll_cen_gen.sv
// Directed bench for the fractional clock-enable generator: lock timing,
// ratio patterns, write rejection, write blocking during settle, phase
// clamping and asynchronous reset.
module tb_pll_cen_gen;
    logic refclk = 1'b0;
    logic rst    = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    pll_cen_gen_if #(.NUM_CH(3), .ACC_W(16)) bus ();

    pll_cen_gen #(.NUM_CH(3), .ACC_W(16), .LOCK_CYCLES(16)) dut (
        .refclk (refclk),
        .rst    (rst),
        .cfg    (bus)
    );

    always #5 refclk = ~refclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // One-cycle write pulse; called 1 time unit after a rising edge.
    task automatic do_write(input logic [2:0] ch, input logic [15:0] num,
                            input logic [15:0] den, input logic [15:0] ph);
        bus.cfg_ch    = ch;
        bus.cfg_num   = num;
        bus.cfg_den   = den;
        bus.cfg_phase = ph;
        bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    // Called right after the accepting edge: 16 edges of settle, lock on the last.
    task automatic settle_check(input string tag);
        check_eq({tag, "_lk0"}, {31'd0, bus.locked}, 32'd0);
        check_eq({tag, "_cen0"}, {29'd0, bus.cen}, 32'd0);
        for (int i = 0; i < 15; i++) begin
            tick();
            check_eq({tag, "_lk"}, {31'd0, bus.locked}, 32'd0);
            check_eq({tag, "_cen"}, {29'd0, bus.cen}, 32'd0);
            check_eq({tag, "_rdy"}, {31'd0, bus.cfg_ready}, 32'd0);
        end
        tick();
        check_eq({tag, "_lock"}, {31'd0, bus.locked}, 32'd1);
        check_eq({tag, "_cenL"}, {29'd0, bus.cen}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1;
        int c2;
        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = 3'd0;
        bus.cfg_num   = 16'd0;
        bus.cfg_den   = 16'd0;
        bus.cfg_phase = 16'd0;

        // Reset state
        tick();
        tick();
        check_eq("rst_cen", {29'd0, bus.cen}, 32'd0);
        check_eq("rst_locked", {31'd0, bus.locked}, 32'd0);
        check_eq("rst_ready", {31'd0, bus.cfg_ready}, 32'd0);
        check_eq("rst_err", {31'd0, bus.cfg_err}, 32'd0);

        // Reset release: lock on edge 16, cen all-ones from edge 17
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check_eq("pre_lock", {31'd0, bus.locked}, 32'd0);
        end
        tick();
        check_eq("lock_e16", {31'd0, bus.locked}, 32'd1);
        check_eq("cen_e16", {29'd0, bus.cen}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("cen_11", {29'd0, bus.cen}, 32'd7);
            check_eq("ready_lk", {31'd0, bus.cfg_ready}, 32'd1);
        end

        // ch1 = 1/4 phase 0: pulses on LOCKED cycles 4, 8, 12
        do_write(3'd1, 16'd1, 16'd4, 16'd0);
        settle_check("w14");
        for (int i = 1; i <= 12; i++) begin
            tick();
            check_eq("ch1_q", {29'd0, bus.cen}, {29'd0, 1'b1, (i % 4 == 0), 1'b1});
        end

        // ch2 = 3/8 phase 7: 1,0,1 first; 300 pulses over 800 cycles
        do_write(3'd2, 16'd3, 16'd8, 16'd7);
        settle_check("w38");
        c1 = 0;
        c2 = 0;
        for (int i = 1; i <= 800; i++) begin
            tick();
            if (bus.cen[2]) c2++;
            if (bus.cen[1]) c1++;
            if (i == 1) check_eq("ch2_L1", {31'd0, bus.cen[2]}, 32'd1);
            if (i == 2) check_eq("ch2_L2", {31'd0, bus.cen[2]}, 32'd0);
            if (i == 3) check_eq("ch2_L3", {31'd0, bus.cen[2]}, 32'd1);
            if (i == 4) check_eq("ch0_L4", {31'd0, bus.cen[0]}, 32'd1);
        end
        check_eq("ch2_cnt800", c2, 32'd300);
        check_eq("ch1_cnt800", c1, 32'd200);

        // Rejected writes: num>den, ch out of range, num==0, den==0
        do_write(3'd0, 16'd5, 16'd4, 16'd0);
        check_eq("rej_err", {31'd0, bus.cfg_err}, 32'd1);
        check_eq("rej_lock", {31'd0, bus.locked}, 32'd1);
        check_eq("rej_cen0", {31'd0, bus.cen[0]}, 32'd1);
        tick();
        check_eq("rej_err_1cyc", {31'd0, bus.cfg_err}, 32'd0);
        check_eq("rej_cen0b", {31'd0, bus.cen[0]}, 32'd1);
        do_write(3'd3, 16'd1, 16'd2, 16'd0);
        check_eq("ch3_err", {31'd0, bus.cfg_err}, 32'd1);
        check_eq("ch3_lock", {31'd0, bus.locked}, 32'd1);
        tick();
        check_eq("ch3_err_1cyc", {31'd0, bus.cfg_err}, 32'd0);
        do_write(3'd0, 16'd0, 16'd2, 16'd0);
        check_eq("num0_err", {31'd0, bus.cfg_err}, 32'd1);
        do_write(3'd0, 16'd0, 16'd0, 16'd0);
        check_eq("den0_err", {31'd0, bus.cfg_err}, 32'd1);
        check_eq("den0_lock", {31'd0, bus.locked}, 32'd1);
        tick();

        // cfg_valid held through SETTLE: A accepted, B only on first LOCKED cycle
        bus.cfg_ch    = 3'd0;
        bus.cfg_num   = 16'd1;
        bus.cfg_den   = 16'd3;
        bus.cfg_phase = 16'd0;
        bus.cfg_valid = 1'b1;
        tick();
        check_eq("hold_accA", {31'd0, bus.locked}, 32'd0);
        bus.cfg_num   = 16'd1;
        bus.cfg_den   = 16'd2;
        bus.cfg_phase = 16'd1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check_eq("hold_lk", {31'd0, bus.locked}, 32'd0);
            check_eq("hold_err", {31'd0, bus.cfg_err}, 32'd0);
        end
        tick();
        check_eq("hold_trans_lock", {31'd0, bus.locked}, 32'd1);
        check_eq("hold_trans_err", {31'd0, bus.cfg_err}, 32'd0);
        tick();
        bus.cfg_valid = 1'b0;
        check_eq("hold_accB", {31'd0, bus.locked}, 32'd0);
        check_eq("hold_accB_err", {31'd0, bus.cfg_err}, 32'd0);
        settle_check("wB");
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_eq("ch0_half", {31'd0, bus.cen[0]}, {31'd0, (i % 2 == 1)});
        end

        // Phase clamp: ch1 1/4 phase 200 -> acc 3, pulses on cycles 1 and 5
        do_write(3'd1, 16'd1, 16'd4, 16'd200);
        settle_check("wclamp");
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_eq("ch1_clamp", {31'd0, bus.cen[1]}, {31'd0, (i == 1 || i == 5)});
        end

        // Reset mid-SETTLE after a ch1 write; configuration returns to 1/1
        do_write(3'd1, 16'd1, 16'd3, 16'd0);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        #1;
        check_eq("arst_cen", {29'd0, bus.cen}, 32'd0);
        check_eq("arst_locked", {31'd0, bus.locked}, 32'd0);
        check_eq("arst_ready", {31'd0, bus.cfg_ready}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check_eq("rr_pre", {31'd0, bus.locked}, 32'd0);
        end
        tick();
        check_eq("rr_lock", {31'd0, bus.locked}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("rr_cen111", {29'd0, bus.cen}, 32'd7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
